// File: rtl/clkdiv_pkg.sv
// Shared defaults and types for the clock-divider / clock-enable generator.
package clkdiv_pkg;

  localparam int unsigned NCH_DEF         = 4;
  localparam int unsigned DIV_W_DEF       = 8;
  localparam int unsigned DEF_DIV_DEF     = 2;
  localparam int unsigned LOCK_CYCLES_DEF = 16;

  // Select-field width; never below one bit so a single-channel build still has a port.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CH_W_DEF = clog2_min1(NCH_DEF);

  typedef logic [DIV_W_DEF-1:0] div_t;
  typedef logic [CH_W_DEF-1:0]  ch_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: period counter, live/pending divisor and registered clkout/ce.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned DEF_DIV = DEF_DIV_DEF
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en_i,
  input  logic             wr_en_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             clkout_o,
  output logic             ce_o,
  output logic             apply_c,
  output logic             pend_nxt_c
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_v_q, pend_v_d;
  logic             clkout_q, clkout_d;
  logic             ce_q, ce_d;
  logic             term;

  // Next-state: count, terminal-count update, pending-divisor capture.
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_div_d = pend_div_q;
    pend_v_d   = pend_v_q;
    clkout_d   = 1'b0;
    ce_d       = 1'b0;
    apply_c    = 1'b0;
    term       = (cnt_q == (div_q - DIV_W'(1)));

    if (en_i) begin
      ce_d     = term;
      clkout_d = (cnt_q < (div_q >> 1));
      cnt_d    = term ? '0 : (cnt_q + DIV_W'(1));
      // Retune only at a period boundary so no runt pulse is emitted.
      apply_c  = pend_v_q && term;
    end else begin
      cnt_d    = '0;
      // Idle channel has no phase to protect; take the update at once.
      apply_c  = pend_v_q;
    end

    if (apply_c) begin
      div_d    = pend_div_q;
      pend_v_d = 1'b0;
      cnt_d    = '0;
    end

    if (wr_en_i) begin
      pend_div_d = wr_div_i;
      pend_v_d   = 1'b1;
    end
  end

  assign pend_nxt_c = pend_v_d;

  // Channel state registers with synchronous reset.
  always_ff @(posedge clkin) begin
    if (reset) begin
      cnt_q      <= '0;
      div_q      <= DIV_W'(DEF_DIV);
      pend_div_q <= '0;
      pend_v_q   <= 1'b0;
      clkout_q   <= 1'b0;
      ce_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_div_q <= pend_div_d;
      pend_v_q   <= pend_v_d;
      clkout_q   <= clkout_d;
      ce_q       <= ce_d;
    end
  end

  assign clkout_o = clkout_q;
  assign ce_o     = ce_q;

endmodule

// File: rtl/clkdiv_gen.sv
// Multi-channel clock divider / enable generator with write decode and lock tracking.
module clkdiv_gen
  import clkdiv_pkg::*;
#(
  parameter  int unsigned NCH         = NCH_DEF,
  parameter  int unsigned DIV_W       = DIV_W_DEF,
  parameter  int unsigned DEF_DIV     = DEF_DIV_DEF,
  parameter  int unsigned LOCK_CYCLES = LOCK_CYCLES_DEF,
  localparam int unsigned CH_W        = clog2_min1(NCH)
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic [NCH-1:0]   enclk,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             lock,
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   ce
);

  localparam int unsigned LK_W = $clog2(LOCK_CYCLES + 1);

  logic [NCH-1:0]  apply;
  logic [NCH-1:0]  pend_nxt;
  logic [NCH-1:0]  wr_en;
  logic            wr_ok;
  logic [LK_W-1:0] lk_q, lk_d;
  logic            lock_q, lock_d;
  logic            ready_q, ready_d;

  // Accept a write only when idle, addressed to a real channel, with a non-zero divisor.
  always_comb begin
    wr_ok = cfg_we && ready_q && (32'(cfg_ch) < NCH) && (cfg_div != '0);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr_en[i] = wr_ok && (cfg_ch == CH_W'(i));

    clkdiv_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clkin      (clkin),
      .reset      (reset),
      .en_i       (enclk[i]),
      .wr_en_i    (wr_en[i]),
      .wr_div_i   (cfg_div),
      .clkout_o   (clkout[i]),
      .ce_o       (ce[i]),
      .apply_c    (apply[i]),
      .pend_nxt_c (pend_nxt[i])
    );
  end

  // Lock counter restarts on any applied divisor, else saturates at LOCK_CYCLES.
  always_comb begin
    lk_d    = lk_q;
    lock_d  = 1'b0;
    ready_d = ~|pend_nxt;
    if (|apply) begin
      lk_d = '0;
    end else if (lk_q != LK_W'(LOCK_CYCLES)) begin
      lk_d = lk_q + LK_W'(1);
    end
    lock_d = (lk_d == LK_W'(LOCK_CYCLES));
  end

  // Global status registers.
  always_ff @(posedge clkin) begin
    if (reset) begin
      lk_q    <= '0;
      lock_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      lk_q    <= lk_d;
      lock_q  <= lock_d;
      ready_q <= ready_d;
    end
  end

  assign cfg_ready = ready_q;
  assign lock      = lock_q;

endmodule

// File: tb/tb_clkdiv_gen.sv
// Self-checking bench for clkdiv_gen: phase-arithmetic model plus directed literal checks.
module tb_clkdiv_gen;
  import clkdiv_pkg::*;

  localparam int NCH = 4;
  localparam int L   = 16;

  logic       clkin;
  logic       reset;
  logic [3:0] enclk;
  logic       cfg_we;
  ch_t        cfg_ch;
  div_t       cfg_div;
  logic       cfg_ready;
  logic       lock;
  logic [3:0] clkout;
  logic [3:0] ce;

  int n_cmp = 0;
  int n_bad = 0;

  clkdiv_gen #(
    .NCH         (4),
    .DIV_W       (8),
    .DEF_DIV     (2),
    .LOCK_CYCLES (16)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .enclk     (enclk),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .lock      (lock),
    .clkout    (clkout),
    .ce        (ce)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each channel remembers the edge index where its current period started.
  int   md[NCH];
  int   mst[NCH];
  int   mpd[NCH];
  bit   mpv[NCH];
  int   mlk;
  int   n = 0;
  int   ph;
  bit   any_ap;
  bit   ap;
  bit   rdy;
  logic [3:0] e_clk, e_ce;
  logic e_lock, e_rdy;

  always begin : model
    @(posedge clkin);
    n++;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        md[i] = 2; mst[i] = n; mpv[i] = 1'b0; mpd[i] = 0;
      end
      mlk = 0; e_clk = '0; e_ce = '0; e_lock = 1'b0; e_rdy = 1'b1;
    end else begin
      any_ap = 1'b0;
      rdy = 1'b1;
      for (int i = 0; i < NCH; i++) if (mpv[i]) rdy = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (enclk[i]) begin
          ph       = (n - 1 - mst[i]) % md[i];
          e_ce[i]  = (ph == md[i] - 1);
          e_clk[i] = (ph < md[i] / 2);
          ap       = mpv[i] && (ph == md[i] - 1);
        end else begin
          e_ce[i]  = 1'b0;
          e_clk[i] = 1'b0;
          mst[i]   = n;
          ap       = mpv[i];
        end
        if (ap) begin
          md[i] = mpd[i]; mpv[i] = 1'b0; mst[i] = n; any_ap = 1'b1;
        end
      end
      mlk    = any_ap ? 0 : ((mlk < L) ? mlk + 1 : L);
      e_lock = (mlk == L);
      if (cfg_we && rdy && (cfg_div != 0) && (int'(cfg_ch) < NCH)) begin
        mpd[cfg_ch] = int'(cfg_div);
        mpv[cfg_ch] = 1'b1;
      end
      e_rdy = 1'b1;
      for (int i = 0; i < NCH; i++) if (mpv[i]) e_rdy = 1'b0;
    end
    #1;
    chk("m_clkout", 32'(clkout), 32'(e_clk));
    chk("m_ce", 32'(ce), 32'(e_ce));
    chk("m_lock", 32'(lock), 32'(e_lock));
    chk("m_ready", 32'(cfg_ready), 32'(e_rdy));
  end

  task automatic step(input int k);
    repeat (k) @(negedge clkin);
  endtask

  task automatic wr(input int ch, input int dv);
    cfg_we  = 1'b1;
    cfg_ch  = ch_t'(ch);
    cfg_div = div_t'(dv);
    step(1);
    cfg_we  = 1'b0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 300; k++) begin
      if (cfg_ready) break;
      step(1);
    end
    chk("wait_ready", 32'(cfg_ready), 32'd1);
  endtask

  logic [4:0] s_clk, s_ce;
  logic [6:0] s_ce0, s_ce3;
  logic       prev;

  initial begin : stim
    reset = 1'b1; enclk = 4'hF; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    step(3);
    reset = 1'b0;

    // Defaults after release
    step(1);
    chk("rst_clkout_e1", 32'(clkout), 32'hF);
    chk("rst_ce_e1", 32'(ce), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    step(1);
    chk("rst_clkout_e2", 32'(clkout), 32'h0);
    chk("rst_ce_e2", 32'(ce), 32'hF);
    step(13);
    chk("lock_e15", 32'(lock), 32'd0);
    step(1);
    chk("lock_e16", 32'(lock), 32'd1);

    // ch1 -> 5, written at cnt==0
    wr(1, 5);
    chk("ready_low_after_wr", 32'(cfg_ready), 32'd0);
    step(1);
    chk("lock_drop_apply", 32'(lock), 32'd0);
    chk("ready_back", 32'(cfg_ready), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step(1);
      s_clk[4-k] = clkout[1];
      s_ce[4-k]  = ce[1];
    end
    chk("ch1_clk_seq", 32'(s_clk), 32'b11000);
    chk("ch1_ce_seq", 32'(s_ce), 32'b00001);
    step(10);
    chk("relock_minus1", 32'(lock), 32'd0);
    step(1);
    chk("relock", 32'(lock), 32'd1);

    // Illegal writes
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = '0;
    step(1);
    cfg_we = 1'b0;
    chk("div0_ready", 32'(cfg_ready), 32'd1);
    step(1);
    chk("div0_lock", 32'(lock), 32'd1);
    wr(0, 2);
    chk("same_div_pending", 32'(cfg_ready), 32'd0);
    wr(2, 9);
    wait_ready();
    step(2);
    chk("same_div_lockdrop", 32'(lock), 32'd0);
    prev = clkout[2];
    step(1);
    chk("ch2_still_div2", 32'(clkout[2] ^ prev), 32'd1);

    // ch2 -> 1
    wr(2, 1);
    wait_ready();
    step(2);
    for (int k = 0; k < 4; k++) begin
      chk("d1_ce", 32'(ce[2]), 32'd1);
      chk("d1_clk", 32'(clkout[2]), 32'd0);
      step(1);
    end

    // Disabled channel applies immediately; then phase-aligned re-enable
    enclk = 4'b0111;
    step(1);
    chk("dis_clk3", 32'(clkout[3]), 32'd0);
    chk("dis_ce3", 32'(ce[3]), 32'd0);
    wr(3, 7);
    chk("dis_pending", 32'(cfg_ready), 32'd0);
    step(1);
    chk("dis_applied", 32'(cfg_ready), 32'd1);
    chk("dis_lockdrop", 32'(lock), 32'd0);
    wr(0, 7);
    wait_ready();
    enclk = 4'b0110;
    step(2);
    enclk = 4'hF;
    for (int k = 0; k < 7; k++) begin
      step(1);
      s_ce0[6-k] = ce[0];
      s_ce3[6-k] = ce[3];
    end
    chk("reen_ce0", 32'(s_ce0), 32'b0000001);
    chk("reen_ce3", 32'(s_ce3), 32'b0000001);

    // Reset with an update pending
    wr(1, 9);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    chk("rst2_clkout", 32'(clkout), 32'hF);
    chk("rst2_ce", 32'(ce), 32'h0);
    chk("rst2_ready", 32'(cfg_ready), 32'd1);
    step(14);
    chk("rst2_lock_e15", 32'(lock), 32'd0);
    step(1);
    chk("rst2_lock_e16", 32'(lock), 32'd1);

    // Max divisor and an odd divisor
    wr(0, 255);
    wait_ready();
    wr(2, 3);
    wait_ready();
    step(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
